// File: rtl/bitwise16_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : bitwise16_pkg                                              |
// | Shared widths, opcode encoding and the 16-bit bitwise logic function |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bitwise16_pkg;

  localparam int W = 16;
  localparam int N = 4;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_NAND = 2'd1,
    OP_OR   = 2'd2,
    OP_XOR  = 2'd3
  } op_e;

  // NAND reuses the AND path and inverts it.
  function automatic logic [W-1:0] logic_op(input op_e op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W-1:0] w_and;
    logic [W-1:0] w_res;
    w_and = a & b;
    case (op)
      OP_AND:  w_res = w_and;
      OP_NAND: w_res = ~w_and;
      OP_OR:   w_res = a | b;
      default: w_res = a ^ b;
    endcase
    return w_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bitwise16_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : bitwise16_arbiter_if                                     |
// | Four-requester issue bus plus single tagged response channel         |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
interface bitwise16_arbiter_if;
  import bitwise16_pkg::*;

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*2-1:0] req_op;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_data;
  logic [1:0]     resp_id;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );

endinterface
`default_nettype wire

// File: rtl/bitwise16_arbiter_rr_pick4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_pick4                                                   |
// | Combinational 4-way round-robin picker starting after last grant     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_pick4 (
  input  wire logic [3:0] i_req,
  input  wire logic [1:0] i_last_grant,
  output logic      [3:0] o_grant,
  output logic      [1:0] o_idx,
  output logic            o_any
);

  logic [1:0] w_cand;

  // Walk last_grant+1 .. last_grant+4 (mod 4); the first set request wins.
  always_comb begin
    o_grant = 4'b0000;
    o_idx   = 2'd0;
    o_any   = 1'b0;
    w_cand  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = i_last_grant + 2'(k);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bitwise16_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bitwise16_arbiter                                          |
// | Shares one 16-bit AND/NAND/OR/XOR unit among four requesters         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bitwise16_arbiter
  import bitwise16_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          reset,
  bitwise16_arbiter_if.slave bus
);

  logic           r_resp_valid;
  logic [W-1:0]   r_resp_data;
  logic [1:0]     r_resp_id;
  logic [1:0]     r_last_grant;

  logic           w_can_issue;
  logic [N-1:0]   w_req_gated;
  logic [N-1:0]   w_grant;
  logic [1:0]     w_idx;
  logic           w_any;
  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  op_e            w_op;
  logic [W-1:0]   w_result;

  assign w_can_issue = !r_resp_valid || bus.resp_ready;
  assign w_req_gated = bus.req_valid & {N{w_can_issue}};

  rr_pick4 u_pick (
    .i_req        (w_req_gated),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_idx        (w_idx),
    .o_any        (w_any)
  );

  assign w_a      = bus.req_a[w_idx*W +: W];
  assign w_b      = bus.req_b[w_idx*W +: W];
  assign w_op     = op_e'(bus.req_op[w_idx*2 +: 2]);
  assign w_result = logic_op(w_op, w_a, w_b);

  // Ready is forced low while reset is held, independent of the clock.
  assign bus.req_ready  = reset ? '0 : w_grant;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_id    = r_resp_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= 2'd0;
      r_last_grant <= 2'd3;
    end else if (w_any) begin
      r_resp_valid <= 1'b1;
      r_resp_data  <= w_result;
      r_resp_id    <= w_idx;
      r_last_grant <= w_idx;
    end else if (r_resp_valid && bus.resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitwise16_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_bitwise16_arbiter                                       |
// | Self-checking bench for bitwise16_arbiter against a behavioural model|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_bitwise16_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  bitwise16_arbiter_if bus ();

  bitwise16_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state: what the response register should hold.
  bit          m_valid;
  logic [15:0] m_data;
  int          m_id;
  int          m_lg;

  task automatic m_reset();
    m_valid = 0; m_data = 16'h0000; m_id = 0; m_lg = 3;
  endtask

  function automatic int m_winner();
    int i;
    if (m_valid && !bus.resp_ready) return -1;
    for (int k = 1; k <= 4; k++) begin
      i = (m_lg + k) % 4;
      if (bus.req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready();
    int w;
    w = m_winner();
    return (w >= 0) ? (4'b0001 << w) : 4'b0000;
  endfunction

  function automatic logic [15:0] m_calc(int i);
    logic [15:0] a, b;
    a = bus.req_a[i*16 +: 16];
    b = bus.req_b[i*16 +: 16];
    case (bus.req_op[i*2 +: 2])
      2'd0:    return a & b;
      2'd1:    return ~(a & b);
      2'd2:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Advance the model with the current inputs, then cross one rising edge.
  task automatic tick();
    int w;
    w = m_winner();
    if (w >= 0) begin
      m_data = m_calc(w); m_id = w; m_valid = 1; m_lg = w;
    end else if (m_valid && bus.resp_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [15:0] a, logic [15:0] b, logic [1:0] op);
    bus.req_a[i*16 +: 16] = a;
    bus.req_b[i*16 +: 16] = b;
    bus.req_op[i*2 +: 2]  = op;
  endtask

  task automatic test_reset();
    bus.req_valid = 4'b1111;
    #1;
    total++;
    if (bus.req_ready !== 4'b0000 || bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_initial ready=%b valid=%b want ready=0000 valid=0", bus.req_ready, bus.resp_valid);
    end
    @(posedge clk); #2;
    reset = 1'b0; m_reset();
    bus.req_valid = 4'b0100; bus.resp_ready = 1'b0;
    set_req(2, 16'hAAAA, 16'h5555, 2'd2);
    tick();
    total++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 16'hFFFF || bus.resp_id !== 2'd2) begin
      bad++; $display("FAIL reset_prefill valid=%b data=%h id=%0d want 1 ffff 2", bus.resp_valid, bus.resp_data, bus.resp_id);
    end
    #2 reset = 1'b1;
    bus.req_valid = 4'b1111; bus.resp_ready = 1'b1;
    #1;
    total++;
    if (bus.resp_valid !== 1'b0 || bus.resp_data !== 16'h0000 || bus.resp_id !== 2'd0 || bus.req_ready !== 4'b0000) begin
      bad++; $display("FAIL reset_async valid=%b data=%h id=%0d ready=%b want 0 0000 0 0000",
                      bus.resp_valid, bus.resp_data, bus.resp_id, bus.req_ready);
    end
    @(posedge clk); #1;
    total++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      bad++; $display("FAIL reset_held valid=%b ready=%b want 0 0000", bus.resp_valid, bus.req_ready);
    end
    reset = 1'b0; m_reset();
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) begin
      bad++; $display("FAIL reset_first_ready got=%b want=0001", bus.req_ready);
    end
    tick();
    total++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0) begin
      bad++; $display("FAIL reset_first_grant valid=%b id=%0d want 1 0", bus.resp_valid, bus.resp_id);
    end
  endtask

  task automatic test_single_op();
    logic [15:0] exp_tbl [4];
    exp_tbl = '{16'hF000, 16'h0FFF, 16'hFFF0, 16'h0FF0};
    bus.req_valid = 4'b0100; bus.resp_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      set_req(2, 16'hF0F0, 16'hFF00, 2'(j));
      #1;
      total++;
      if (bus.req_ready !== 4'b0100) begin
        bad++; $display("FAIL single_ready op=%0d got=%b want=0100", j, bus.req_ready);
      end
      tick();
      total++;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== exp_tbl[j] || bus.resp_id !== 2'd2) begin
        bad++; $display("FAIL single_op op=%0d valid=%b data=%h id=%0d want 1 %h 2",
                        j, bus.resp_valid, bus.resp_data, bus.resp_id, exp_tbl[j]);
      end
    end
  endtask

  task automatic test_round_robin();
    reset = 1'b1; #1 reset = 1'b0; m_reset();
    for (int i = 0; i < 4; i++) set_req(i, 16'($urandom), 16'($urandom), 2'($urandom));
    bus.req_valid = 4'b1111; bus.resp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      total++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'(n % 4) || bus.resp_data !== m_data) begin
        bad++; $display("FAIL round_robin step=%0d valid=%b id=%0d data=%h want 1 %0d %h",
                        n, bus.resp_valid, bus.resp_id, bus.resp_data, n % 4, m_data);
      end
    end
  endtask

  task automatic test_backpressure();
    bus.req_valid = 4'b0010; bus.resp_ready = 1'b1;
    set_req(1, 16'h1234, 16'hFFFF, 2'd0);
    tick();
    bus.req_valid = 4'b1001; bus.resp_ready = 1'b0;
    set_req(0, 16'h00FF, 16'h0F0F, 2'd3);
    set_req(3, 16'hC3C3, 16'h0000, 2'd1);
    for (int n = 0; n < 5; n++) begin
      #1;
      total++;
      if (bus.req_ready !== 4'b0000 || bus.resp_data !== 16'h1234 || bus.resp_id !== 2'd1 || bus.resp_valid !== 1'b1) begin
        bad++; $display("FAIL backpressure_hold cyc=%0d ready=%b data=%h id=%0d valid=%b want 0000 1234 1 1",
                        n, bus.req_ready, bus.resp_data, bus.resp_id, bus.resp_valid);
      end
      tick();
    end
    bus.resp_ready = 1'b1;
    tick();
    total++;
    if (bus.resp_id !== 2'd3 || bus.resp_data !== 16'hFFFF) begin
      bad++; $display("FAIL backpressure_release1 id=%0d data=%h want 3 ffff", bus.resp_id, bus.resp_data);
    end
    tick();
    total++;
    if (bus.resp_id !== 2'd0 || bus.resp_data !== 16'h0FF0) begin
      bad++; $display("FAIL backpressure_release2 id=%0d data=%h want 0 0ff0", bus.resp_id, bus.resp_data);
    end
  endtask

  task automatic test_back_to_back();
    bus.req_valid = 4'b0001; bus.resp_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      set_req(0, 16'($urandom), 16'($urandom), 2'($urandom));
      #1;
      total++;
      if (bus.resp_valid !== 1'b1 || bus.req_ready !== 4'b0001) begin
        bad++; $display("FAIL b2b_ready n=%0d valid=%b ready=%b want 1 0001", n, bus.resp_valid, bus.req_ready);
      end
      tick();
      total++;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== m_data || bus.resp_id !== 2'd0) begin
        bad++; $display("FAIL b2b_result n=%0d valid=%b data=%h id=%0d want 1 %h 0",
                        n, bus.resp_valid, bus.resp_data, bus.resp_id, m_data);
      end
    end
  endtask

  task automatic test_withdrawn();
    // last grant is 0 here, so requester 1 would outrank requester 2.
    bus.resp_ready = 1'b1;
    set_req(1, 16'h1111, 16'h1111, 2'd2);
    set_req(2, 16'h0F0F, 16'h00FF, 2'd2);
    bus.req_valid = 4'b0110;
    #1;
    total++;
    if (bus.req_ready !== 4'b0010) begin
      bad++; $display("FAIL withdrawn_before got=%b want=0010", bus.req_ready);
    end
    bus.req_valid = 4'b0100;
    #1;
    total++;
    if (bus.req_ready !== 4'b0100) begin
      bad++; $display("FAIL withdrawn_ready got=%b want=0100", bus.req_ready);
    end
    tick();
    total++;
    if (bus.resp_id !== 2'd2 || bus.resp_data !== 16'h0FFF) begin
      bad++; $display("FAIL withdrawn_grant id=%0d data=%h want 2 0fff", bus.resp_id, bus.resp_data);
    end
    bus.req_valid = 4'b1111;
    #1;
    total++;
    if (bus.req_ready !== 4'b1000) begin
      bad++; $display("FAIL withdrawn_lastgrant ready=%b want=1000", bus.req_ready);
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] er;
    for (int n = 0; n < 400; n++) begin
      bus.req_valid  = 4'($urandom);
      bus.resp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 4; i++) set_req(i, 16'($urandom), 16'($urandom), 2'($urandom));
      #1;
      er = m_ready();
      total++;
      if (bus.req_ready !== er) begin
        bad++; $display("FAIL random_ready n=%0d got=%b want=%b", n, bus.req_ready, er);
      end
      tick();
      total++;
      if (bus.resp_valid !== m_valid || (m_valid && (bus.resp_data !== m_data || bus.resp_id !== 2'(m_id)))) begin
        bad++; $display("FAIL random_resp n=%0d valid=%b data=%h id=%0d want %b %h %0d",
                        n, bus.resp_valid, bus.resp_data, bus.resp_id, m_valid, m_data, m_id);
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 4'b0000;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_op     = '0;
    bus.resp_ready = 1'b0;
    m_reset();
    #2;
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_withdrawn();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bitwise16_arbiter.md
# bitwise16_arbiter

Round-robin arbiter and sequencer that shares one 16-bit bitwise logic unit (AND/NAND/OR/XOR) among four requesters. Each requester presents operands and an opcode on a valid/ready channel. The arbiter grants at most one requester per cycle and computes the result through the shared 16-bit datapath. It returns the result, tagged with the requester index, through a single registered response channel with backpressure. It sits between the CPU-side issue ports and the gate-level 16-bit logic blocks.

## Interface
- N, 4, number of requesters (fixed at 4 in this revision; index width 2)
- W, 16, operand/result width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  N  per-requester request valid
- req_ready  output  N  per-requester accept; one-hot or zero
- req_a  input  N*W  operand A, requester i at bits [i*W +: W]
- req_b  input  N*W  operand B, same packing
- req_op  input  N*2  opcode, requester i at [i*2 +: 2]; 0=AND, 1=NAND, 2=OR, 3=XOR
- resp_valid  output  1  response valid
- resp_ready  input  1  response consumer ready
- resp_data  output  W  result
- resp_id  output  2  index of the requester that produced resp_data

## Operation
- Output stage: one register holding resp_valid, resp_data and resp_id.
- can_issue = !resp_valid || resp_ready.
- Arbitration is combinational each cycle over req_valid, gated by can_issue.
  - Priority order starts at last_grant+1 (mod 4) and wraps.
  - The first valid requester in that order wins.
- req_ready[i] = can_issue && (i == winner) && req_valid[i]. It is zero for all requesters when none are valid or can_issue=0.
- On handshake (req_valid[i] && req_ready[i]):
  - The W-bit result of op(req_a[i], req_b[i]) is registered into resp_data.
  - resp_id <= i, resp_valid <= 1, last_grant <= i.
- Without a new handshake, a resp_valid && resp_ready cycle clears resp_valid.
- Simultaneous drain and issue in one cycle: the new result replaces the old and resp_valid stays 1.
- While resp_valid && !resp_ready, resp_data and resp_id are held stable and no requester is granted.
- last_grant changes only on a handshake, so stalls do not rotate priority.
- Requester-side rule: a requester holds its valid and payload until accepted. Dropping valid early is legal; the arbiter simply skips that requester.
- Reset values, applied asynchronously: resp_valid=0, resp_data=16'h0000, resp_id=0, last_grant=3 (so requester 0 has first priority). req_ready=0 during reset.
- Reset asserted mid-transaction discards any held response and does not generate a response.

## Timing
- Latency: a request accepted at edge k gives resp_valid=1 with its result after edge k, visible in cycle k+1.
- Throughput: one result per cycle while resp_ready=1.
- Fairness: with all four requesters continuously valid and resp_ready=1, grants follow 0,1,2,3,0,… Any requester waits at most 3 handshakes.
- req_ready depends combinationally on req_valid and resp_ready. There is no combinational path from req_a, req_b or req_op to any output.
- The opcode decode and the 16-bit logic are single-cycle combinational, feeding the output register.

## Structure
- Shared package `bitwise16_pkg`: W=16, N=4, opcode constants OP_AND=2'd0, OP_NAND=2'd1, OP_OR=2'd2, OP_XOR=2'd3.
- Sub-module `rr_pick4`: purely combinational round-robin picker. Inputs: 4-bit request and 2-bit last_grant. Outputs: one-hot grant, 2-bit index and any-valid.
- The AND path uses the existing 16-bit AND gate block. NAND is its inversion. OR and XOR use the team's 16-bit gate blocks.
- The operand mux is selected by the picker index.
- This module holds only the output register and last_grant.

## Test plan
- Reset: assert reset mid-run with resp_valid=1 → resp_valid=0, resp_data=0, resp_id=0, req_ready=0 immediately, without waiting for a clock edge. The first grant after release goes to requester 0.
- Single op: requester 2, a=16'hF0F0, b=16'hFF00, op=AND → next cycle resp_valid=1, resp_data=16'hF000, resp_id=2. Repeat the same operands:
  - NAND → 16'h0FFF
  - OR → 16'hFFF0
  - XOR → 16'h0FF0
- Round-robin: all four valid continuously, resp_ready=1 → resp_id sequence 0,1,2,3,0,1 on consecutive cycles.
- Backpressure: issue requester 1 (a=16'h1234, b=16'hFFFF, AND), then hold resp_ready=0 for 5 cycles with requesters 0 and 3 valid:
  - resp_data stays 16'h1234 and req_ready stays 0.
  - After release, the next id is 3, then 0.
- Drain plus issue: resp_valid=1, resp_ready=1, requester 0 valid in the same cycle → resp_valid remains 1 and the new result is present the next cycle. No bubble.
- Withdrawn request: requester 1 drops valid before grant while requesters 1 and 2 compete → requester 2 is granted and last_grant=2.
